// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: select-width derivation and mode encoding.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned sw_of(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_stream_n_rr_arbiter.sv
// Combinational cyclic-priority search: first requester at or after ptr, wrapping at N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned SW = sw_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int unsigned w_idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(ptr) + k) % N;
            if (!gnt_any && req[w_idx[SW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = w_idx[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready stream multiplexer with registered output, manual or round-robin select.
module mux_stream_n
    import mux_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SW    = sw_of(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    input  logic                 rr_en,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_ch
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SW-1:0]    r_out_ch;
    logic [SW-1:0]    r_ptr;

    mode_e            w_mode;
    logic             w_load_ok;
    logic [SW-1:0]    w_arb_idx;
    logic             w_arb_any;
    logic [SW-1:0]    w_gnt;
    logic             w_gnt_any;
    logic [N-1:0]     w_in_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SW-1:0]    w_ptr_nxt;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    assign w_mode    = mode_e'(rr_en);
    assign w_load_ok = !r_out_valid || out_ready;

    always_comb begin
        if (w_mode == MODE_RR) begin
            w_gnt     = w_arb_idx;
            w_gnt_any = w_arb_any;
        end else begin
            w_gnt     = sel;
            w_gnt_any = (32'(sel) < N);
        end
    end

    // Ready is forced low during reset so producers never see a phantom handshake.
    always_comb begin
        w_in_ready = '0;
        w_data     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(w_gnt) == i) begin
                w_in_ready[i] = w_gnt_any && w_load_ok && rst_n;
                w_data        = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer    = |(in_valid & w_in_ready);
    assign w_ptr_nxt = (32'(w_gnt) + 1 >= N) ? '0 : w_gnt + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_ch    <= w_gnt;
                r_out_valid <= 1'b1;
                if (w_mode == MODE_RR) r_ptr <= w_ptr_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule
